// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and counter-width helper for the bit-serial ALU sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_ZERO = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_NOTA = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter must reach WIDTH, hence the +1.
  function automatic int seq_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/alu_serial_sequencer_if.sv
// Request, response and 1-bit slice pins of the serial ALU sequencer; slave = sequencer side.
interface alu_serial_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [2:0]       in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
  logic             flag_zero;
  logic             flag_ovf;

  logic             alu_a;
  logic             alu_b;
  logic             alu_cin;
  logic [2:0]       alu_sel;
  logic             alu_out;
  logic             alu_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_op, out_ready, alu_out, alu_cout,
    output in_ready, out_valid, out_result, out_cout, flag_zero, flag_ovf,
           alu_a, alu_b, alu_cin, alu_sel
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_op, out_ready, alu_out, alu_cout,
    input  in_ready, out_valid, out_result, out_cout, flag_zero, flag_ovf,
           alu_a, alu_b, alu_cin, alu_sel
  );

endinterface

// File: rtl/alu_seq_shiftreg.sv
// Operand/result shift-register bank: parallel load, LSB taps, result filled from the MSB end.
module alu_seq_shiftreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bit,
  output logic             o_a0,
  output logic             o_b0,
  output logic [WIDTH-1:0] o_result
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
    end else if (i_load) begin
      r_a <= i_a;
      r_b <= i_b;
    end else if (i_shift) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      // LSB-first arrival: after WIDTH inserts the first bit sits at bit 0.
      r_res <= {i_bit, r_res[WIDTH-1:1]};
    end
  end

  assign o_a0     = r_a[0];
  assign o_b0     = r_b[0];
  assign o_result = r_res;

endmodule

// File: rtl/alu_serial_sequencer.sv
// Runs a WIDTH-bit ALU op through an external 1-bit slice, LSB first; result after WIDTH+1 cycles.
// Zero/overflow flags are built only when ALU_SEQ_FLAGS_EN is defined, otherwise tied to 0.
module alu_serial_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_serial_sequencer_if.slave bus
);

  localparam int CNT_W = seq_cnt_width(WIDTH);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic             r_carry;

  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_arith;
  logic             w_a0;
  logic             w_b0;
  logic [WIDTH-1:0] w_res;

  assign w_load  = (r_state == S_IDLE) && bus.in_valid;
  assign w_shift = (r_state == S_SHIFT);
  assign w_last  = w_shift && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

  alu_seq_shiftreg #(
    .WIDTH(WIDTH)
  ) u_shiftreg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_a     (bus.in_a),
    .i_b     (bus.in_b),
    .i_bit   (bus.alu_out),
    .o_a0    (w_a0),
    .o_b0    (w_b0),
    .o_result(w_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_op    <= bus.in_op;
            r_carry <= bus.in_cin;
            r_cnt   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // The slice's carry/borrow feeds straight back as the next bit's carry-in.
          r_carry <= bus.alu_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic r_msb_cin;
  logic r_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_msb_cin <= 1'b0;
      r_zero    <= 1'b0;
    end else if (w_last) begin
      // Carry into the sign bit; XOR with carry out gives signed overflow.
      r_msb_cin <= r_carry;
      r_zero    <= ({bus.alu_out, w_res[WIDTH-1:1]} == '0);
    end
  end

  assign bus.flag_zero = r_zero;
  assign bus.flag_ovf  = w_arith & (r_msb_cin ^ r_carry);
`else
  assign bus.flag_zero = 1'b0;
  assign bus.flag_ovf  = 1'b0;
`endif

  assign bus.in_ready   = (r_state == S_IDLE);
  assign bus.out_valid  = (r_state == S_DONE);
  assign bus.out_result = w_res;
  assign bus.out_cout   = w_arith & r_carry;

  assign bus.alu_a   = w_shift & w_a0;
  assign bus.alu_b   = w_shift & w_b0;
  assign bus.alu_cin = w_shift & r_carry;
  assign bus.alu_sel = r_op;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Bench for alu_serial_sequencer: behavioural 1-bit slice plus an arithmetic reference model.
module tb_alu_serial_sequencer;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cyc;
  int   tr_n;
  logic tr_cin [0:15];
  logic tr_cout[0:15];
  logic sl_out;
  logic sl_cout;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_serial_sequencer_if #(.WIDTH(8)) bus ();

  alu_serial_sequencer #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // External gate-level slice stand-in.
  always_comb begin
    sl_out  = 1'b0;
    sl_cout = 1'b0;
    case (bus.alu_sel)
      OP_ZERO: sl_out = 1'b0;
      OP_ADD:  sl_out = bus.alu_a ^ bus.alu_b ^ bus.alu_cin;
      OP_AND:  sl_out = bus.alu_a & bus.alu_b;
      OP_OR:   sl_out = bus.alu_a | bus.alu_b;
      OP_SUB:  sl_out = bus.alu_a ^ bus.alu_b ^ bus.alu_cin;
      OP_XOR:  sl_out = bus.alu_a ^ bus.alu_b;
      OP_XNOR: sl_out = ~(bus.alu_a ^ bus.alu_b);
      OP_NOTA: sl_out = ~bus.alu_a;
      default: sl_out = 1'b0;
    endcase
    if (bus.alu_sel[2])
      sl_cout = (~bus.alu_a & bus.alu_b) | (~(bus.alu_a ^ bus.alu_b) & bus.alu_cin);
    else
      sl_cout = (bus.alu_a & bus.alu_b) | (bus.alu_a & bus.alu_cin) | (bus.alu_b & bus.alu_cin);
  end

  assign bus.alu_out  = sl_out;
  assign bus.alu_cout = sl_cout;

  function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                 input logic cin, output logic [7:0] res, output logic co,
                                 output logic zf, output logic ov);
    logic [8:0] w;
    res = 8'h00; co = 1'b0; ov = 1'b0;
    case (op)
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        res = w[7:0]; co = w[8];
        ov = (a[7] == b[7]) && (res[7] != a[7]);
      end
      OP_SUB: begin
        w = {1'b0, a} - {1'b0, b} - {8'd0, cin};
        res = w[7:0]; co = w[8];
        ov = (a[7] != b[7]) && (res[7] != a[7]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_NOTA: res = ~a;
      default: res = 8'h00;
    endcase
    zf = FLAGS_ON && (res == 8'h00);
    ov = FLAGS_ON && ov;
  endfunction

  // Issues one op with out_ready high; returns observed outputs and accept-to-valid latency.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic cin, output logic [7:0] res, output logic co,
                        output logic zf, output logic ov, output int lat);
    int n;
    @(negedge clk);
    bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_cin = cin; bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.in_a = 8'($urandom); bus.in_b = 8'($urandom);
    bus.in_op = 3'($urandom); bus.in_cin = 1'($urandom);
    n = 1; tr_n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      if (tr_n < 16) begin
        tr_cin[tr_n]  = bus.alu_cin;
        tr_cout[tr_n] = bus.alu_cout;
        tr_n++;
      end
      @(posedge clk); #1;
      n++;
    end
    if (bus.out_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL result_timeout out_valid=%b required=1", bus.out_valid);
    end
    lat = n;
    res = bus.out_result; co = bus.out_cout; zf = bus.flag_zero; ov = bus.flag_ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [18:0] obs;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.in_a = 8'h00; bus.in_b = 8'h00; bus.in_op = 3'd0; bus.in_cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs = {bus.in_ready, bus.out_valid, bus.out_cout, bus.flag_zero, bus.flag_ovf,
           bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_sel, bus.out_result};
    checks++;
    if (obs !== 19'h40000) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=%h", obs, 19'h40000);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [7:0] r; logic c, z, v; int lat;
    run_op(8'h5A, 8'h3C, OP_ADD, 1'b0, r, c, z, v, lat);
    checks++; if (r !== 8'h96) begin failures++; $display("FAIL add_result got=%h want=96", r); end
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL add_cout got=%b want=0", c); end
    checks++; if (v !== FLAGS_ON) begin failures++; $display("FAIL add_ovf got=%b want=%b", v, FLAGS_ON); end
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL add_zero got=%b want=0", z); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL add_latency got=%0d want=9", lat); end
  endtask

  task automatic test_sub();
    logic [7:0] r; logic c, z, v; int lat;
    run_op(8'h10, 8'h20, OP_SUB, 1'b0, r, c, z, v, lat);
    checks++; if (r !== 8'hF0) begin failures++; $display("FAIL sub1_result got=%h want=f0", r); end
    checks++; if (c !== 1'b1) begin failures++; $display("FAIL sub1_borrow got=%b want=1", c); end
    checks++; if (v !== 1'b0) begin failures++; $display("FAIL sub1_ovf got=%b want=0", v); end
    run_op(8'h80, 8'h01, OP_SUB, 1'b0, r, c, z, v, lat);
    checks++; if (r !== 8'h7F) begin failures++; $display("FAIL sub2_result got=%h want=7f", r); end
    checks++; if (c !== 1'b0) begin failures++; $display("FAIL sub2_borrow got=%b want=0", c); end
    checks++; if (v !== FLAGS_ON) begin failures++; $display("FAIL sub2_ovf got=%b want=%b", v, FLAGS_ON); end
  endtask

  task automatic test_logic_sweep();
    logic [2:0] ops [6];
    logic [7:0] exps[6];
    logic [7:0] r; logic c, z, v; int lat;
    ops  = '{OP_ZERO, OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NOTA};
    exps = '{8'h00, 8'h81, 8'hE7, 8'h66, 8'h99, 8'h3C};
    for (int i = 0; i < 6; i++) begin
      run_op(8'hC3, 8'hA5, ops[i], 1'($urandom), r, c, z, v, lat);
      checks++;
      if (r !== exps[i]) begin failures++; $display("FAIL logic_result op=%0d got=%h want=%h", ops[i], r, exps[i]); end
      checks++;
      if (c !== 1'b0) begin failures++; $display("FAIL logic_cout op=%0d got=%b want=0", ops[i], c); end
      checks++;
      if (z !== (FLAGS_ON && i == 0)) begin failures++; $display("FAIL logic_zero op=%0d got=%b want=%b", ops[i], z, (FLAGS_ON && i == 0)); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] er, held; logic ec, ez, ev; int n;
    logic [10:0] obs, want;
    ref_op(8'h37, 8'h4C, OP_ADD, 1'b1, er, ec, ez, ev);
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_a = 8'h37; bus.in_b = 8'h4C; bus.in_op = OP_ADD; bus.in_cin = 1'b1; bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_ready got=%b want=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    held = bus.out_result;
    checks++;
    if (held !== er || bus.out_cout !== ec) begin
      failures++; $display("FAIL bp_result got=%h/%b want=%h/%b", held, bus.out_cout, er, ec);
    end
    want = {1'b1, 1'b0, ec, er};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_a = 8'($urandom); bus.in_op = 3'($urandom);
      @(posedge clk); #1;
      obs = {bus.out_valid, bus.in_ready, bus.out_cout, bus.out_result};
      checks++;
      if (obs !== want) begin failures++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, obs, want); end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release valid=%b ready=%b want=0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [18:0] obs;
    logic [7:0] r; logic c, z, v; int lat, seen;
    @(negedge clk);
    bus.in_a = 8'h5A; bus.in_b = 8'h3C; bus.in_op = OP_SUB; bus.in_cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_busy in_ready=%b want=0", bus.in_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    obs = {bus.in_ready, bus.out_valid, bus.out_cout, bus.flag_zero, bus.flag_ovf,
           bus.alu_a, bus.alu_b, bus.alu_cin, bus.alu_sel, bus.out_result};
    checks++;
    if (obs !== 19'h40000) begin failures++; $display("FAIL midrst_outputs got=%h want=%h", obs, 19'h40000); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL midrst_idle bad_cycles=%0d want=0", seen); end
    run_op(8'hFF, 8'h01, OP_ADD, 1'b0, r, c, z, v, lat);
    checks++;
    if ({r, c, z} !== {8'h00, 1'b1, FLAGS_ON}) begin
      failures++; $display("FAIL midrst_add got=%h/%b/%b want=00/1/%b", r, c, z, FLAGS_ON);
    end
  endtask

  task automatic test_chained_carry();
    logic [7:0] r; logic c, z, v; int lat;
    run_op(8'hFF, 8'h00, OP_ADD, 1'b1, r, c, z, v, lat);
    checks++;
    if (r !== 8'h00 || c !== 1'b1) begin failures++; $display("FAIL chain_result got=%h/%b want=00/1", r, c); end
    checks++;
    if (tr_n !== 8) begin failures++; $display("FAIL chain_shift_cycles got=%0d want=8", tr_n); end
    checks++;
    if (tr_cin[0] !== 1'b1) begin failures++; $display("FAIL chain_first_cin got=%b want=1", tr_cin[0]); end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (tr_cin[i] !== tr_cout[i-1]) begin
        failures++; $display("FAIL chain_probe bit=%0d alu_cin=%b prev_cout=%b", i, tr_cin[i], tr_cout[i-1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r, er; logic c, z, v, ec, ez, ev; int lat, prev;
    logic [7:0] a, b; logic [2:0] op; logic ci;
    prev = -1;
    for (int i = 0; i < 3; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); ci = 1'($urandom);
      ref_op(a, b, op, ci, er, ec, ez, ev);
      run_op(a, b, op, ci, r, c, z, v, lat);
      checks++;
      if ({r, c} !== {er, ec}) begin failures++; $display("FAIL b2b_result got=%h/%b want=%h/%b", r, c, er, ec); end
      if (prev >= 0) begin
        checks++;
        if (acc_cyc - prev !== 10) begin failures++; $display("FAIL b2b_spacing got=%0d want=10", acc_cyc - prev); end
      end
      prev = acc_cyc;
    end
  endtask

  task automatic test_random();
    logic [7:0] r, er; logic c, z, v, ec, ez, ev; int lat;
    logic [7:0] a, b; logic [2:0] op; logic ci;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); ci = 1'($urandom);
      ref_op(a, b, op, ci, er, ec, ez, ev);
      run_op(a, b, op, ci, r, c, z, v, lat);
      checks++;
      if ({r, c, z, v} !== {er, ec, ez, ev} || lat !== 9) begin
        failures++;
        $display("FAIL rand op=%0d a=%h b=%h cin=%b got=%h/%b/%b/%b lat=%0d want=%h/%b/%b/%b lat=9",
                 op, a, b, ci, r, c, z, v, lat, er, ec, ez, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_sweep();
    test_backpressure();
    test_reset_mid_op();
    test_chained_carry();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
Bit-serial sequencer that executes a WIDTH-bit ALU operation on a single external 1-bit ALU slice, one bit per clock, LSB first.
- Accepts operands and a 3-bit opcode over a valid/ready handshake.
- Drives the slice's a/b/cin/select pins and threads the slice's carry/borrow output back as the next bit's carry-in.
- Assembles the result word and returns it with carry and flags over a second valid/ready handshake.
- Sits between the datapath issue logic and the 1-bit slice, so one gate-level slice serves full-width operations.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  sequencer can accept a request
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  initial carry/borrow-in (chained multiword ops)
in_op  input  3  opcode: 0 zero, 1 add, 2 and, 3 or, 4 sub, 5 xor, 6 xnor, 7 not-A
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result word
out_cout  output  1  final carry (op1) / borrow (op4); 0 for other ops
flag_zero  output  1  result == 0 (see Optional Feature)
flag_ovf  output  1  signed overflow, op1/op4 only (see Optional Feature)
alu_a  output  1  bit to slice operand A
alu_b  output  1  bit to slice operand B
alu_cin  output  1  carry/borrow into slice
alu_sel  output  3  slice function select
alu_out  input  1  slice result bit (combinational from alu_* outputs)
alu_cout  input  1  slice carry (sel[2]=0) / borrow (sel[2]=1)

Behaviour:
- Synchronous, active-high reset returns the block to IDLE. All outputs reset to 0 except in_ready, which resets to 1. Operand, result, carry and counter registers clear to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a, in_b, in_op, in_cin into the carry register; clear the counter; go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - alu_a = a_sh[0], alu_b = b_sh[0], alu_cin = carry register, alu_sel = latched op.
  - Each cycle: shift a_sh and b_sh right; shift alu_out into the result MSB (result shifts right); carry <= alu_cout; counter++.
  - Before the last-bit update, also register msb_cin <= carry (for overflow).
  - After bit WIDTH-1 is captured, go to DONE.
- DONE:
  - out_valid=1; out_result, out_cout and flags are stable.
  - On out_ready: go to IDLE. out_valid drops the next cycle.
- Latency: accept at cycle 0 → out_valid asserted at cycle WIDTH+1 (9 for WIDTH=8).
- Throughput: one operation per WIDTH+2 cycles. No overlap and no bypass from DONE to SHIFT.
- in_ready is 0 in SHIFT and DONE. in_valid is ignored there, and in_* may change freely.
- out_cout = final carry register for op 1 and op 4, else 0.
- Outside SHIFT, alu_a/alu_b/alu_cin are 0 and alu_sel holds the last latched op.
- Back-pressure: DONE holds indefinitely with all outputs stable while out_ready=0.
- Reset mid-operation (in SHIFT or DONE) aborts the operation. No result is emitted, and the block is in IDLE on the cycle after reset deasserts.
- The opcode is always latched. The sequencer never re-samples in_op during SHIFT.

Optional Feature:
Macro ALU_SEQ_FLAGS_EN.
- Defined:
  - flag_zero = (out_result == 0), registered with the result.
  - flag_ovf = msb_cin XOR final carry, for op 1 and op 4; 0 for other ops.
  - Both flags are valid with out_valid and held while in DONE.
- Undefined:
  - flag_zero and flag_ovf are tied to 0.
  - No msb_cin register and no zero-detect logic are built.
  - Ports remain present.

Decomposition:
- Shared package alu_seq_pkg holds:
  - opcode localparams OP_ZERO..OP_NOTA (0..7)
  - FSM state enum (IDLE/SHIFT/DONE)
  - helper constant for WIDTH-derived counter width
- Natural sub-module: alu_seq_shiftreg. This is the operand/result shift-register bank with load, shift, bit-0 taps and MSB insert. The FSM and counter stay in the top module.
- The 1-bit slice is external and is not instantiated here.

Test Plan:
- Add, WIDTH=8, op=1, A=0x5A, B=0x3C, cin=0 → result 0x96, out_cout=0, flag_ovf=1, flag_zero=0, out_valid exactly 9 cycles after accept.
- Sub, op=4, A=0x10, B=0x20, cin=0 → result 0xF0, out_cout(borrow)=1, flag_ovf=0. Then A=0x80, B=0x01 → 0x7F, ovf=1.
- Logic sweep, A=0xC3, B=0xA5, ops 0,2,3,5,6,7 → 0x00, 0x81, 0xE7, 0x66, 0x99, 0x3C. out_cout=0 for all; flag_zero=1 only for op 0.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → out_valid/out_result stable and in_ready=0 throughout. in_valid pulses while busy are not accepted.
- Reset mid-op: assert rst at SHIFT cycle 4 → all outputs at reset values next cycle and no out_valid. A new add (0xFF+0x01, cin=0) then gives 0x00 with cout=1 and flag_zero=1.
- Chained carry: in_cin=1, op=1, A=0xFF, B=0x00 → 0x00, cout=1. Probe that alu_cin equals the previous cycle's alu_cout on every SHIFT cycle.
